writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges unbuffered ALU results and FIFO-buffered load responses onto one register-file write port.
// Optional macro WB_FORWARD_EN adds a combinational forwarding query against the registered write.
module writeback_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_thread,
    input  logic [3:0]  alu_rd,
    input  logic [17:0] alu_data,
    input  logic        alu_pred_en,
    input  logic        alu_pred,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_thread,
    input  logic [3:0]  mem_rd,
    input  logic [17:0] mem_data,
    output logic [3:0]  write_thread,
    output logic [3:0]  write_rd,
    output logic [17:0] write_data,
    output logic        write_en,
    output logic        predicate_write_en,
    output logic        predicate_in
`ifdef WB_FORWARD_EN
    ,
    input  logic [3:0]  fwd_thread,
    input  logic [3:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [17:0] fwd_data
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef struct packed {
        logic [3:0]  thread;
        logic [3:0]  rd;
        logic [17:0] data;
    } entry_t;

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve;

    logic            fifo_nonempty;
    logic            push;
    logic            alu_win;
    logic            head_win;
    entry_t          head;

    assign fifo_nonempty = (count != '0);
    assign alu_ready     = (starve != SW'(STARVE_LIMIT));
    assign mem_ready     = (count < CW'(FIFO_DEPTH));
    assign push          = mem_valid && mem_ready;
    assign alu_win       = alu_valid && alu_ready;
    assign head_win      = !alu_win && fifo_nonempty;
    assign head          = fifo_mem[rd_ptr];

    // Storage carries no reset; emptiness is tracked solely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{thread: mem_thread, rd: mem_rd, data: mem_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (head_win) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !head_win) begin
                count <= count + CW'(1);
            end else if (!push && head_win) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (fifo_nonempty && alu_win) begin
            starve <= starve + SW'(1);
        end else begin
            starve <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_thread       <= '0;
            write_rd           <= '0;
            write_data         <= '0;
            write_en           <= 1'b0;
            predicate_write_en <= 1'b0;
            predicate_in       <= 1'b0;
        end else if (alu_win) begin
            write_thread       <= alu_thread;
            write_rd           <= alu_rd;
            write_data         <= alu_data;
            write_en           <= (alu_rd > 4'd3);
            predicate_write_en <= alu_pred_en;
            predicate_in       <= alu_pred;
        end else if (head_win) begin
            write_thread       <= head.thread;
            write_rd           <= head.rd;
            write_data         <= head.data;
            write_en           <= (head.rd > 4'd3);
            predicate_write_en <= 1'b0;
        end else begin
            write_en           <= 1'b0;
            predicate_write_en <= 1'b0;
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_hit  = write_en && (write_thread == fwd_thread) && (write_rd == fwd_rs);
    assign fwd_data = write_data;
`endif

endmodule
